// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register and ALU operand front end of the RV32I pipeline.
// It latches the decoded ID fields and forwards MEM/WB results onto the ALU
// operands. It loads a bubble on Flush or on a load-use hazard, and it raises
// the load-use hazard flag that stalls IF/ID.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   Stall, Flush                    hold / kill the EX entry
//   id_*                            decoded fields from ID
//   mem_rd/mem_reg_write/mem_result EX/MEM forwarding source
//   wb_rd/wb_reg_write/wb_result    MEM/WB forwarding source
//   SrcA, SrcB, Operation           ALU operands and operation code
//   ex_valid/ex_reg_write/ex_mem_read/ex_mem_write/ex_rd
//                                   registered control bits and destination register
//   ex_store_data                   forwarded rs2 value, used as store data
//   load_use_hazard                 combinational stall request for IF/ID
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  id_operation,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      load_use_hazard
);

  logic                      valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic                      alu_src_q, alu_src_d;
  logic [OPCODE_LENGTH-1:0]  operation_q, operation_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;

  logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

  // x0 is hard-wired to zero, so a write to it must never be forwarded.
  assign mem_hit_rs1 = mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q);
  assign mem_hit_rs2 = mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q);
  assign wb_hit_rs1  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs1_q);
  assign wb_hit_rs2  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs2_q);

  // MEM holds the younger result, so it takes precedence over WB.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_hit_rs1)     fwd_rs1 = mem_result;
    else if (wb_hit_rs1) fwd_rs1 = wb_result;
    fwd_rs2 = rs2_data_q;
    if (mem_hit_rs2)     fwd_rs2 = mem_result;
    else if (wb_hit_rs2) fwd_rs2 = wb_result;
  end

  assign SrcA          = fwd_rs1;
  assign SrcB          = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign Operation     = operation_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_rd         = rd_q;

  assign load_use_hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                           ((rd_q == id_rs1) || (rd_q == id_rs2));

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    operation_d = operation_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (Flush || (!Stall && load_use_hazard)) begin
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      alu_src_d   = 1'b0;
      operation_d = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (Stall) begin
      // A WB result that retires while the stage is held would otherwise be
      // lost, because it is no longer visible on the WB port after it leaves.
      if (wb_hit_rs1) rs1_data_d = wb_result;
      if (wb_hit_rs2) rs2_data_d = wb_result;
    end else begin
      valid_d     = id_valid;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      alu_src_d   = id_alu_src;
      operation_d = id_operation;
      reg_write_d = id_reg_write & id_valid;
      mem_read_d  = id_mem_read  & id_valid;
      mem_write_d = id_mem_write & id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      operation_q <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      operation_q <= operation_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

endmodule
